// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory arbiter: default widths and FSM state encoding.
package dm_arb_pkg;

  localparam int unsigned AW_DEF = 5;
  localparam int unsigned DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/dm_arb_if.sv
// Requester/memory bundle for dm_arb; slave is the arbiter side, master the requester + memory side.
interface dm_arb_if #(
  parameter int unsigned AW = dm_arb_pkg::AW_DEF,
  parameter int unsigned DW = dm_arb_pkg::DW_DEF
);

  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic          done0, done1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_D;
  logic          mem_Memwrite;
  logic          mem_Memtoreg;
  logic [DW-1:0] mem_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    output gnt0, gnt1, done0, done1, rdata, busy,
           mem_A, mem_D, mem_Memwrite, mem_Memtoreg
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    input  gnt0, gnt1, done0, done1, rdata, busy,
           mem_A, mem_D, mem_Memwrite, mem_Memtoreg
  );

endinterface

// File: rtl/dm_arb_rr_pick2.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the one not granted last.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = (req0 & req1) ? ~last : req1;
  end

endmodule

// File: rtl/dm_arb.sv
// Two-requester data-memory arbiter: IDLE -> ISSUE -> RESP, one access per three cycles.
module dm_arb
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic    Clk,
  input  logic    Reset,
  dm_arb_if.slave bus
);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic pick_winner;
  logic pick_valid;

  rr_pick2 u_pick (
    .req0   (bus.req0),
    .req1   (bus.req1),
    .last   (last_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // addr_q/wdata_q only load on a grant, so they double as the held mem_A/mem_D values.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = ISSUE;
          owner_d = pick_winner;
          last_d  = pick_winner;
          we_d    = pick_winner ? bus.we1    : bus.we0;
          addr_d  = pick_winner ? bus.addr1  : bus.addr0;
          wdata_d = pick_winner ? bus.wdata1 : bus.wdata0;
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (!we_q) rdata_d = bus.mem_out;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory read data lands after the ISSUE edge, so rdata bypasses mem_out during RESP
  // and the captured copy holds it from then on.
  always_comb begin
    bus.gnt0         = (state_q != IDLE) && !owner_q;
    bus.gnt1         = (state_q != IDLE) &&  owner_q;
    bus.done0        = (state_q == RESP) && !owner_q;
    bus.done1        = (state_q == RESP) &&  owner_q;
    bus.busy         = (state_q != IDLE);
    bus.mem_Memwrite = (state_q == ISSUE) &&  we_q;
    bus.mem_Memtoreg = (state_q == ISSUE) && !we_q;
    bus.mem_A        = addr_q;
    bus.mem_D        = wdata_q;
    bus.rdata        = ((state_q == RESP) && !we_q) ? bus.mem_out : rdata_q;
  end

endmodule

// File: doc/dm_arb.md
DM_ARB -- requirements
Module: dm_arb

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AW  5   data-memory word address width
  DW  32  data word width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  Clk          in   1   single clock; all state changes on its rising edge
  Reset        in   1   asynchronous, active-low reset
  req0, req1   in   1   access request from requester 0 / 1
  we0, we1     in   1   1 = write, 0 = read (per requester)
  addr0, addr1 in   AW  word address (per requester)
  wdata0, wdata1 in DW  write data (per requester)
  gnt0, gnt1   out  1   grant; high from ISSUE through RESP of the owning transaction
  done0, done1 out  1   one-cycle completion pulse in RESP
  rdata        out  DW  read data; valid while done0/done1 is high on a read
  busy         out  1   high in ISSUE and RESP
  mem_A        out  AW  to memory address
  mem_D        out  DW  to memory write data
  mem_Memwrite out  1   to memory write enable
  mem_Memtoreg out  1   to memory read enable
  mem_out      in   DW  from memory registered read data

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE and RESP.
REQ-004 IDLE SHALL sample req0/req1 each cycle; with any request it SHALL latch winner id, we, addr and wdata, and enter ISSUE next cycle; with no request it SHALL stay in IDLE.
REQ-005 Arbitration SHALL be round-robin: sole requester wins; on simultaneous requests the requester not granted last wins; a 1-bit last-grant pointer updates on every grant.
REQ-006 ISSUE SHALL last exactly one cycle and drive mem_A/mem_D from latched values, mem_Memwrite = latched we and mem_Memtoreg = not latched we; RESP follows unconditionally.
REQ-007 Outside ISSUE, mem_Memwrite and mem_Memtoreg SHALL be 0; mem_A and mem_D SHALL hold their last-driven values.
REQ-008 RESP SHALL last exactly one cycle, pulse done of the owner and, for a read, register mem_out into rdata so rdata is valid in that same RESP cycle (mem_out is valid after the ISSUE edge); IDLE follows.
REQ-009 rdata SHALL hold its value except on read completion; writes SHALL NOT alter it.
REQ-010 Latency: request seen in IDLE at cycle n -> ISSUE at n+1 -> done at n+2; peak throughput is one access per 3 cycles.
REQ-011 Requester inputs SHALL be ignored outside IDLE; a request dropped or changed after its grant SHALL NOT abort or alter the latched transaction.
REQ-012 A requester keeping req high through its done cycle SHALL be treated as a new request in the following IDLE cycle, subject to REQ-005.
REQ-013 gnt0 and gnt1 SHALL never be high together; done SHALL only pulse for the granted requester.

Reset
REQ-014 Reset low SHALL asynchronously force: state IDLE; gnt0, gnt1, done0, done1, busy, mem_Memwrite, mem_Memtoreg = 0; rdata, mem_A, mem_D = 0; last-grant pointer = 1, so requester 0 wins the first contended arbitration.
REQ-015 Reset during ISSUE or RESP SHALL abandon the transaction with no done pulse; the memory write strobe SHALL deassert immediately.

Structure
REQ-016 State encoding (IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2) and AW/DW defaults SHALL reside in the shared CPU package.
REQ-017 The round-robin picker SHALL be one sub-module, rr_pick2 (inputs req0, req1, last; outputs winner, valid), purely combinational; the rest is a single flat FSM.

Verification
REQ-018 Single read: memory word 3 preloaded with 32'hDEADBEEF; req0 = 1, we0 = 0, addr0 = 3 for one cycle in IDLE -> ISSUE drives mem_A = 3, mem_Memtoreg = 1; two cycles after the request, done0 = 1 and rdata = 32'hDEADBEEF.
REQ-019 Write then read: req1 writes 32'h12345678 to addr 7, then reads addr 7 -> mem_Memwrite pulses exactly one cycle with mem_D = 32'h12345678; the second done1 gives rdata = 32'h12345678, and rdata is unchanged by the write.
REQ-020 Contention: req0 and req1 held high after reset -> grants alternate 0,1,0,1 with done at 3-cycle spacing; gnt0 and gnt1 are never high together.
REQ-021 Mid-transaction change: after gnt0, addr0 changes from 4 to 9 and req0 drops -> access still hits address 4 and done0 still pulses.
REQ-022 Reset mid-operation: Reset low during ISSUE of a write -> mem_Memwrite drops in the same cycle, no done pulse occurs, state is IDLE, and the next contended arbitration grants requester 0.
